// File: rtl/reg_share_pkg.sv
`default_nettype none
// ============================================================================
// Package     : reg_share_pkg
// Description : Shared state encoding and default parameters for the
//               shared-register arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_share_pkg;

   // Default parameter values for reg_share_arbiter
   localparam int C_DEF_N_REQ    = 4;
   localparam int C_DEF_WIDTH    = 8;
   localparam int C_DEF_MAX_HOLD = 8;

   // Hold counter width covers MAX_HOLD up to 255
   localparam int C_HOLD_W = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage : reg_share_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Searches req_i starting
//               at (last_owner_i+1) mod N_REQ and returns the first set bit.
// Ports       : req_i          - request vector
//               last_owner_i   - index of the previous grant holder
//               winner_o       - one-hot winner (all zero if no request)
//               winner_idx_o   - binary index of the winner
//               valid_o        - high when any request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import reg_share_pkg::*;
#(
   parameter int N_REQ = C_DEF_N_REQ,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    last_owner_i,
   output logic [N_REQ-1:0] winner_o,
   output logic [IW-1:0]    winner_idx_o,
   output logic             valid_o
);

   always_comb begin : p_pick
      int          w_cand;
      logic [IW-1:0] w_cidx;
      logic        w_found;
      w_cand       = 0;
      w_cidx       = '0;
      w_found      = 1'b0;
      winner_o     = '0;
      winner_idx_o = '0;
      // k runs 1..N_REQ so the previous owner is examined last
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = (int'(last_owner_i) + k) % N_REQ;
         w_cidx = IW'(w_cand);
         if (!w_found && req_i[w_cidx]) begin
            w_found          = 1'b1;
            winner_o[w_cidx] = 1'b1;
            winner_idx_o     = w_cidx;
         end
      end
      valid_o = w_found;
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arbiter
// Description : Round-robin arbiter guarding a single shared data register.
//               One owner at a time may write q; ownership is bounded to
//               MAX_HOLD cycles, with a timeout pulse on a forced release.
// Ports       : clk     - clock
//               reset   - synchronous active-low reset
//               req     - per-requester level request
//               we      - per-requester write strobe (owner only)
//               wdata   - packed write data, requester i at [i*WIDTH +: WIDTH]
//               gnt     - registered one-hot grant
//               owner   - current grant holder index (valid while busy)
//               busy    - a grant is held
//               q       - shared register contents
//               timeout - one-cycle pulse on forced release
// Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arbiter
   import reg_share_pkg::*;
#(
   parameter int N_REQ    = C_DEF_N_REQ,
   parameter int WIDTH    = C_DEF_WIDTH,
   parameter int MAX_HOLD = C_DEF_MAX_HOLD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         we,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic [WIDTH-1:0]         q,
   output logic                     timeout
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [C_HOLD_W-1:0] C_MAX = C_HOLD_W'(MAX_HOLD);

   state_t                state_q, state_d;
   logic [N_REQ-1:0]      gnt_q, gnt_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [IW-1:0]         last_q, last_d;
   logic [C_HOLD_W-1:0]   hold_q, hold_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  timeout_q, timeout_d;
   // Low for the first edge after reset so no grant lands on that edge
   logic                  arm_q;

   logic [N_REQ-1:0]      w_pick;
   logic [IW-1:0]         w_pick_idx;
   logic                  w_pick_valid;
   logic [WIDTH-1:0]      w_wd [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign w_wd[i] = wdata[i*WIDTH +: WIDTH];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .req_i        (req),
      .last_owner_i (last_q),
      .winner_o     (w_pick),
      .winner_idx_o (w_pick_idx),
      .valid_o      (w_pick_valid)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      last_d    = last_q;
      hold_d    = hold_q;
      data_d    = data_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm_q && w_pick_valid) begin
               state_d = ST_BUSY;
               gnt_d   = w_pick;
               owner_d = w_pick_idx;
               last_d  = w_pick_idx;
               hold_d  = C_HOLD_W'(1);
            end
         end
         ST_BUSY: begin
            // A write in the final MAX_HOLD cycle still lands
            if (req[owner_q] && we[owner_q]) begin
               data_d = w_wd[owner_q];
            end
            if (!req[owner_q] || (hold_q == C_MAX)) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               hold_d    = '0;
               // Only a release with req still high is "forced"
               timeout_d = req[owner_q];
            end else begin
               hold_d = hold_q + C_HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         last_q    <= IW'(N_REQ - 1);
         hold_q    <= '0;
         data_q    <= '0;
         timeout_q <= 1'b0;
         arm_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         data_q    <= data_d;
         timeout_q <= timeout_d;
         arm_q     <= 1'b1;
      end
   end

   assign gnt     = gnt_q;
   assign owner   = owner_q;
   assign busy    = (state_q == ST_BUSY);
   assign q       = data_q;
   assign timeout = timeout_q;

endmodule : reg_share_arbiter
`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_share_arbiter
// Description : Directed testbench for reg_share_arbiter (N_REQ=4, WIDTH=8,
//               MAX_HOLD=8). The driver applies one input vector per clock
//               and queues the hand-computed outputs expected after that
//               edge; an independent monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   logic [7:0]  q;
   logic        timeout;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] owner;
      logic [7:0] q;
      logic       to;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   step_id = 0;

   reg_share_arbiter #(
      .N_REQ    (4),
      .WIDTH    (8),
      .MAX_HOLD (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .we      (we),
      .wdata   (wdata),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .q       (q),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   // Apply inputs for one edge and queue the outputs expected after it.
   task automatic step(input logic rst_n, input logic [3:0] r,
                       input logic [3:0] w, input logic [31:0] wd,
                       input logic [3:0] eg, input logic [1:0] eo,
                       input logic [7:0] eq, input logic eto);
      exp_t e;
      reset = rst_n;
      req   = r;
      we    = w;
      wdata = wd;
      @(posedge clk);
      e.gnt = eg; e.owner = eo; e.q = eq; e.to = eto; e.id = step_id;
      exp_q.push_back(e);
      step_id++;
      #1;
   endtask

   // Monitor: outputs settle after each edge; compare at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            logic eb;
            e  = exp_q.pop_front();
            eb = |e.gnt;
            total++;
            if (gnt !== e.gnt || busy !== eb || q !== e.q || timeout !== e.to ||
                (eb && owner !== e.owner)) begin
               bad++;
               $display("FAIL step%0d: got gnt=%b owner=%0d busy=%b q=%h to=%b, want gnt=%b owner=%0d busy=%b q=%h to=%b",
                        e.id, gnt, owner, busy, q, timeout, e.gnt, e.owner, eb, e.q, e.to);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] og;
      logic [1:0] oi;

      // Reset for two cycles with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b0, 4'($urandom), 4'($urandom), $urandom, 4'b0000, 2'd0, 8'h00, 1'b0);

      // First edge after reset release: no grant yet; second edge grants 0
      step(1'b1, 4'b0001, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'h00, 1'b0);
      step(1'b1, 4'b0001, 4'b0000, 32'h0, 4'b0001, 2'd0, 8'h00, 1'b0);

      // Owner 0 writes A5; non-owner 3 write of 3C ignored
      step(1'b1, 4'b0001, 4'b1001, 32'h3C0000A5, 4'b0001, 2'd0, 8'hA5, 1'b0);
      step(1'b1, 4'b0001, 4'b1000, 32'h3C000000, 4'b0001, 2'd0, 8'hA5, 1'b0);
      // Owner drops req with we high: no write, normal release
      step(1'b1, 4'b0000, 4'b0001, 32'h00000011, 4'b0000, 2'd0, 8'hA5, 1'b0);
      // we without grant ignored
      step(1'b1, 4'b0000, 4'b1111, 32'hFFFFFFFF, 4'b0000, 2'd0, 8'hA5, 1'b0);

      // Requester 2 holds 3 cycles then drops
      step(1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0100, 2'd2, 8'hA5, 1'b0);
      step(1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0100, 2'd2, 8'hA5, 1'b0);
      step(1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0100, 2'd2, 8'hA5, 1'b0);
      step(1'b1, 4'b0010, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'hA5, 1'b0);
      // 1 and 2 both request: 2 was just served, so 1 wins
      step(1'b1, 4'b0110, 4'b0000, 32'h0, 4'b0010, 2'd1, 8'hA5, 1'b0);

      // req=0110 held: 8-cycle grants alternating 1,2,1,2 with timeouts
      for (int r = 0; r < 4; r++) begin
         og = (r % 2 == 0) ? 4'b0010 : 4'b0100;
         oi = (r % 2 == 0) ? 2'd1 : 2'd2;
         if (r != 0)
            step(1'b1, 4'b0110, 4'b0000, 32'h0, og, oi, 8'hA5, 1'b0);
         for (int k = 0; k < 7; k++)
            step(1'b1, 4'b0110, 4'b0000, 32'h0, og, oi, 8'hA5, 1'b0);
         step(1'b1, 4'b0110, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'hA5, 1'b1);
      end
      step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'hA5, 1'b0);

      // Requester 1 drops exactly when the hold limit is reached: no timeout
      step(1'b1, 4'b0010, 4'b0000, 32'h0, 4'b0010, 2'd1, 8'hA5, 1'b0);
      for (int k = 0; k < 7; k++)
         step(1'b1, 4'b0010, 4'b0000, 32'h0, 4'b0010, 2'd1, 8'hA5, 1'b0);
      step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'hA5, 1'b0);

      // Requester 0 writes in its final forced cycle: write lands, timeout
      step(1'b1, 4'b0001, 4'b0000, 32'h0, 4'b0001, 2'd0, 8'hA5, 1'b0);
      for (int k = 0; k < 7; k++)
         step(1'b1, 4'b0001, 4'b0000, 32'h0, 4'b0001, 2'd0, 8'hA5, 1'b0);
      step(1'b1, 4'b0001, 4'b0001, 32'h000000C3, 4'b0000, 2'd0, 8'hC3, 1'b1);
      step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'hC3, 1'b0);

      // Reset mid-grant with owner writing FF: aborted, q cleared, no timeout
      step(1'b1, 4'b1000, 4'b0000, 32'h0, 4'b1000, 2'd3, 8'hC3, 1'b0);
      step(1'b0, 4'b1000, 4'b1000, 32'hFF000000, 4'b0000, 2'd0, 8'h00, 1'b0);
      step(1'b1, 4'b0001, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'h00, 1'b0);
      step(1'b1, 4'b0001, 4'b0000, 32'h0, 4'b0001, 2'd0, 8'h00, 1'b0);
      step(1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 8'h00, 1'b0);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 4 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_share_arbiter
`default_nettype wire
